// File: rtl/gated_count_sched.sv
// Gated multichannel pulse counter: counts per-channel pulses over a programmable
// window, snapshots all channels at window end and drains them over valid/ready.
module gated_count_sched #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int GATE_W    = 24,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH-1:0]    pulse_i,
  input  logic                 enable_i,
  input  logic [GATE_W-1:0]    gate_len_i,
  output logic                 gate_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [CH_W-1:0]      rd_ch_o,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic                 rd_ovf_o,
  output logic                 rd_last_o
);
  typedef enum logic {IDLE, RUN} run_state_t;
  typedef enum logic {D_IDLE, D_SEND} drain_state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  // Saturating increment: returns {ovf, count}; a pulse arriving at all-ones is lost and flagged.
  function automatic logic [CNT_WIDTH:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                 input logic ovf, input logic pulse);
    if (pulse && (&cnt)) return {1'b1, cnt};
    else if (pulse)      return {ovf, cnt + CNT_WIDTH'(1)};
    else                 return {ovf, cnt};
  endfunction

  run_state_t             state_q;
  drain_state_t           d_state_q;
  logic [GATE_W-1:0]      gate_len_q;
  logic [GATE_W-1:0]      gate_cnt_q;
  logic [CNT_WIDTH-1:0]   live_cnt_q [NUM_CH];
  logic                   live_ovf_q [NUM_CH];
  logic [CNT_WIDTH-1:0]   inc_cnt    [NUM_CH];
  logic                   inc_ovf    [NUM_CH];
  logic [CNT_WIDTH-1:0]   shadow_cnt_q [NUM_CH];
  logic                   shadow_ovf_q [NUM_CH];
  logic [CH_W-1:0]        idx_q;
  logic                   overrun_q;
  logic                   end_win;
  logic                   run_start;
  logic                   xfer;
  logic                   drain_free;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      {inc_ovf[i], inc_cnt[i]} = sat_inc(live_cnt_q[i], live_ovf_q[i], pulse_i[i]);
    end
  end

  assign end_win    = (state_q == RUN) && (gate_cnt_q == gate_len_q - GATE_W'(1));
  assign run_start  = (state_q == IDLE) && enable_i;
  assign xfer       = (d_state_q == D_SEND) && rd_ready_i;
  // The final transfer and a new window end may share a cycle without losing the snapshot.
  assign drain_free = (d_state_q == D_IDLE) || (xfer && (idx_q == LAST_CH));

  // Gate window and live counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gate_len_q <= '0;
      gate_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        live_cnt_q[i] <= '0;
        live_ovf_q[i] <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q    <= RUN;
            gate_len_q <= (gate_len_i == '0) ? GATE_W'(1) : gate_len_i;
          end
        end
        RUN: begin
          if (end_win) begin
            gate_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
              live_cnt_q[i] <= '0;
              live_ovf_q[i] <= 1'b0;
            end
            if (!enable_i) state_q <= IDLE;
          end else begin
            gate_cnt_q <= gate_cnt_q + GATE_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
              live_cnt_q[i] <= inc_cnt[i];
              live_ovf_q[i] <= inc_ovf[i];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Snapshot shadow and readout drain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_state_q <= D_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_cnt_q[i] <= '0;
        shadow_ovf_q[i] <= 1'b0;
      end
    end else begin
      if (run_start) overrun_q <= 1'b0;
      if (xfer) begin
        if (idx_q == LAST_CH) begin
          d_state_q <= D_IDLE;
          idx_q     <= '0;
        end else begin
          idx_q <= idx_q + CH_W'(1);
        end
      end
      if (end_win) begin
        if (drain_free) begin
          d_state_q <= D_SEND;
          idx_q     <= '0;
          for (int i = 0; i < NUM_CH; i++) begin
            shadow_cnt_q[i] <= inc_cnt[i];
            shadow_ovf_q[i] <= inc_ovf[i];
          end
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign gate_o     = (state_q == RUN);
  assign rd_valid_o = (d_state_q == D_SEND);
  assign busy_o     = gate_o | rd_valid_o;
  assign overrun_o  = overrun_q;
  assign rd_ch_o    = idx_q;
  assign rd_cnt_o   = shadow_cnt_q[idx_q];
  assign rd_ovf_o   = shadow_ovf_q[idx_q];
  assign rd_last_o  = (idx_q == LAST_CH) && rd_valid_o;

endmodule

// File: doc/gated_count_sched.md
# gated_count_sched

Gated multichannel count scheduler for the Zynq multichannel counter. It takes one-cycle "pressed" pulses from the per-pin debouncers, one bit per channel. It counts them per channel over a programmable gate window and snapshots all channels at window end. It then drains the snapshot channel by channel over a valid/ready readout port toward the PS-side register/FIFO logic, while the next window is already counting.

## Interface
- NUM_CH, 4: number of input channels (1..16)
- CNT_WIDTH, 16: per-channel count width
- GATE_W, 24: width of gate-length configuration
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  asynchronous reset, active-high
- pulse_i  in  NUM_CH  one-cycle event pulses, one bit per channel, synchronous to clk_i
- enable_i  in  1  run request (level)
- gate_len_i  in  GATE_W  window length in clk_i cycles, sampled on IDLE->RUN; 0 treated as 1
- gate_o  out  1  high while in RUN
- busy_o  out  1  RUN or drain active
- overrun_o  out  1  sticky: a window was discarded because the drain was still active
- rd_valid_o  out  1  readout word valid
- rd_ready_i  in  1  readout consumer ready
- rd_ch_o  out  max(1,$clog2(NUM_CH))  channel index of current word
- rd_cnt_o  out  CNT_WIDTH  snapshot count of rd_ch_o
- rd_ovf_o  out  1  that channel saturated during the window
- rd_last_o  out  1  current word is channel NUM_CH-1

## Operation
- Main FSM has two states, IDLE and RUN.
  - IDLE: live counters held at 0, gate counter at 0, pulse_i ignored.
  - IDLE->RUN when enable_i=1. On that transition: latch gate length L from gate_len_i (0 becomes 1) and clear overrun_o.
  - RUN: each channel increments its live counter on every cycle its pulse_i bit is 1. The gate counter counts 0..L-1.
- End-of-window cycle E is the cycle with gate counter == L-1. On the edge closing E:
  - Each snapshot value is live+pulse_i, so pulses in cycle E are included.
  - All live counters clear to 0.
  - The gate counter clears to 0.
  - If enable_i=0 in cycle E, the FSM goes to IDLE; otherwise RUN continues with the same L.
  - Deasserting enable_i mid-window never truncates the window; the current window always completes.
- Saturation: a live counter stops at all-ones and sets the channel's ovf flag. The ovf flag travels with the snapshot and clears with the live counter.
- Drain FSM has two states, D_IDLE and D_SEND.
  - At the edge closing E, if the drain is in D_IDLE: load the shadow registers (counts plus ovf), set channel index to 0, enter D_SEND.
  - In D_SEND, rd_valid_o=1. A transfer occurs when rd_valid_o & rd_ready_i. Each transfer advances the index by 1.
  - The transfer at index NUM_CH-1 returns the drain to D_IDLE.
  - rd_last_o = (index == NUM_CH-1) & rd_valid_o.
  - While rd_valid_o=1 and rd_ready_i=0, rd_ch_o, rd_cnt_o, rd_ovf_o and rd_last_o hold stable.
- Window end while the drain is in D_SEND: the snapshot is discarded and the shadow registers are untouched. Live counters still clear, and overrun_o sets (sticky).
- Window end in the same cycle as the final transfer: the drain is considered free. The new snapshot loads and rd_valid_o stays high with index 0. No overrun.
- busy_o = gate_o | (drain in D_SEND).

## Timing
- Reset values: gate_o, busy_o, overrun_o, rd_valid_o, rd_ch_o, rd_cnt_o, rd_ovf_o, rd_last_o all 0. Both FSMs idle, all counters 0.
- enable_i sampled high in cycle T: gate_o=1 from T+1; the first window spans T+1..T+L.
- Snapshot latency: window end in cycle E gives rd_valid_o=1 and rd_ch_o=0 in cycle E+1.
- With rd_ready_i held at 1, the drain takes exactly NUM_CH cycles, E+1..E+NUM_CH. Back-to-back windows therefore need L >= NUM_CH to avoid overrun.
- Reset mid-operation: everything returns to reset values immediately (asynchronously). A partial drain is lost.

## Test plan
- Basic window: NUM_CH=4, L=10, enable_i held at 1, rd_ready_i=1. Channel 0 gets 3 pulses, channel 2 gets 7 pulses, including one pulse in cycle E. Required: words (0,3), (1,0), (2,7), (3,0) in E+1..E+4, with rd_last_o only on channel 3 and all ovf=0.
- Back-pressure: rd_ready_i toggles 0,0,1 per word. Required: data is stable while stalled, each word appears exactly once in order, and rd_valid_o drops the cycle after the channel 3 transfer.
- Saturation: CNT_WIDTH=4, L=40, 20 pulses on channel 1. Required: rd_cnt_o=15 and rd_ovf_o=1 for channel 1; the next window starts from 0 with ovf=0.
- Overrun: L=2, NUM_CH=4, rd_ready_i=0 for 10 cycles. Required: overrun_o=1, and the first snapshot is delivered unchanged. overrun_o clears only on the next IDLE->RUN transition.
- Stop and edge cases: deassert enable_i mid-window with L=8. Required: the window completes, one snapshot is drained, gate_o falls after cycle E, and busy_o falls after the last transfer. Then gate_len_i=0: each window is 1 cycle long.
- Async reset asserted during D_SEND at index 2: all outputs read 0 in the same cycle. After reset release with enable_i=1, counting restarts from 0.
